mem_controller: RTL

- Arbitrates load/store requests from the per-thread LSUs of all cores onto a smaller number of external data-memory channels.
- Sits between the cores' LSUs and the data memory model driven by the kernel testbenches (4 channels, 8-bit address, 8-bit data).
- Also instantiable for program memory (1 channel, 16-bit data, read-only) between core fetchers and program memory.
- Each channel runs an independent request/relay FSM; consumers see a simple valid/ready handshake.

---
 rtl/mem_controller_if.sv | 26 ++
 rtl/mem_controller.sv | 129 ++++++++++++
 2 files changed

// File: rtl/mem_controller_if.sv
// mem_controller_if: consumer-side and memory-side handshake bundle; master = controller, slave = consumers plus memory
interface mem_controller_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int NUM_CONSUMERS = 16,
  parameter int NUM_CHANNELS = 4
);
  logic [NUM_CONSUMERS-1:0] consumer_read_valid, consumer_read_ready, consumer_write_valid, consumer_write_ready;
  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address, consumer_write_address;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data, consumer_write_data;
  logic [NUM_CHANNELS-1:0] mem_read_valid, mem_read_ready, mem_write_valid, mem_write_ready;
  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address, mem_write_address;
  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data, mem_write_data;
  modport master (
    input consumer_read_valid, consumer_read_address, consumer_write_valid, consumer_write_address,
    consumer_write_data, mem_read_ready, mem_read_data, mem_write_ready,
    output consumer_read_ready, consumer_read_data, consumer_write_ready, mem_read_valid,
    mem_read_address, mem_write_valid, mem_write_address, mem_write_data
  );
  modport slave (
    output consumer_read_valid, consumer_read_address, consumer_write_valid, consumer_write_address,
    consumer_write_data, mem_read_ready, mem_read_data, mem_write_ready,
    input consumer_read_ready, consumer_read_data, consumer_write_ready, mem_read_valid,
    mem_read_address, mem_write_valid, mem_write_address, mem_write_data
  );
endinterface

// File: rtl/mem_controller.sv
// mem_controller: fixed-priority arbiter of consumer loads/stores onto independent memory channels (ports: clk, async active-high reset, bus = mem_controller_if.master)
module mem_controller #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int NUM_CONSUMERS = 16,
  parameter int NUM_CHANNELS = 4,
  parameter bit WRITE_ENABLE = 1'b1
) (
  input logic clk,
  input logic reset,
  mem_controller_if.master bus
);
  localparam int CW = NUM_CONSUMERS > 1 ? $clog2(NUM_CONSUMERS) : 1;
  typedef enum logic [2:0] {IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING} state_t;
  state_t state_q [NUM_CHANNELS];
  state_t state_d [NUM_CHANNELS];
  logic [CW-1:0] cur_q [NUM_CHANNELS];
  logic [CW-1:0] cur_d [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] claimed_q, claimed_d, taken, wv;
  logic [NUM_CONSUMERS-1:0] rready_q, rready_d, wready_q, wready_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] rdata_q, rdata_d;
  logic [NUM_CHANNELS-1:0] mrv_q, mrv_d, mwv_q, mwv_d;
  logic [NUM_CHANNELS*ADDR_BITS-1:0] mra_q, mra_d, mwa_q, mwa_d;
  logic [NUM_CHANNELS*DATA_BITS-1:0] mwd_q, mwd_d;
  logic found;
  int pick, cur;
  always_comb begin
    state_d = state_q;
    cur_d = cur_q;
    claimed_d = claimed_q;
    rready_d = rready_q;
    wready_d = wready_q;
    rdata_d = rdata_q;
    mrv_d = mrv_q;
    mwv_d = mwv_q;
    mra_d = mra_q;
    mwa_d = mwa_q;
    mwd_d = mwd_q;
    wv = WRITE_ENABLE ? bus.consumer_write_valid : '0;
    taken = claimed_q;
    found = 1'b0;
    pick = 0;
    cur = 0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      found = 1'b0;
      pick = 0;
      cur = int'(cur_q[c]);
      for (int i = NUM_CONSUMERS - 1; i >= 0; i--)
        if ((bus.consumer_read_valid[i] || wv[i]) && !taken[i]) begin
          found = 1'b1;
          pick = i;
        end
      case (state_q[c])
        IDLE: if (found) begin
          // taken makes this consumer invisible to higher-numbered channels this cycle
          taken[pick] = 1'b1;
          claimed_d[pick] = 1'b1;
          cur_d[c] = CW'(pick);
          if (bus.consumer_read_valid[pick]) begin
            mrv_d[c] = 1'b1;
            mra_d[c*ADDR_BITS +: ADDR_BITS] = bus.consumer_read_address[pick*ADDR_BITS +: ADDR_BITS];
            state_d[c] = READ_WAITING;
          end else begin
            mwv_d[c] = 1'b1;
            mwa_d[c*ADDR_BITS +: ADDR_BITS] = bus.consumer_write_address[pick*ADDR_BITS +: ADDR_BITS];
            mwd_d[c*DATA_BITS +: DATA_BITS] = bus.consumer_write_data[pick*DATA_BITS +: DATA_BITS];
            state_d[c] = WRITE_WAITING;
          end
        end
        READ_WAITING: if (bus.mem_read_ready[c]) begin
          mrv_d[c] = 1'b0;
          rdata_d[cur*DATA_BITS +: DATA_BITS] = bus.mem_read_data[c*DATA_BITS +: DATA_BITS];
          rready_d[cur] = 1'b1;
          state_d[c] = READ_RELAYING;
        end
        WRITE_WAITING: if (bus.mem_write_ready[c]) begin
          mwv_d[c] = 1'b0;
          wready_d[cur] = 1'b1;
          state_d[c] = WRITE_RELAYING;
        end
        READ_RELAYING: if (!bus.consumer_read_valid[cur]) begin
          rready_d[cur] = 1'b0;
          claimed_d[cur] = 1'b0;
          state_d[c] = IDLE;
        end
        WRITE_RELAYING: if (!wv[cur]) begin
          wready_d[cur] = 1'b0;
          claimed_d[cur] = 1'b0;
          state_d[c] = IDLE;
        end
        default: state_d[c] = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= '{default: IDLE};
      cur_q <= '{default: '0};
      claimed_q <= '0;
      rready_q <= '0;
      wready_q <= '0;
      rdata_q <= '0;
      mrv_q <= '0;
      mwv_q <= '0;
      mra_q <= '0;
      mwa_q <= '0;
      mwd_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      claimed_q <= claimed_d;
      rready_q <= rready_d;
      wready_q <= wready_d;
      rdata_q <= rdata_d;
      mrv_q <= mrv_d;
      mwv_q <= mwv_d;
      mra_q <= mra_d;
      mwa_q <= mwa_d;
      mwd_q <= mwd_d;
    end
  assign bus.consumer_read_ready = rready_q;
  assign bus.consumer_read_data = rdata_q;
  assign bus.consumer_write_ready = WRITE_ENABLE ? wready_q : '0;
  assign bus.mem_read_valid = mrv_q;
  assign bus.mem_read_address = mra_q;
  assign bus.mem_write_valid = WRITE_ENABLE ? mwv_q : '0;
  assign bus.mem_write_address = WRITE_ENABLE ? mwa_q : '0;
  assign bus.mem_write_data = WRITE_ENABLE ? mwd_q : '0;
endmodule
